// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the RV32IM multiply/divide units.
package rv_muldiv_pkg;
   localparam int XLEN      = 32;
   localparam int DIV_STEPS = 32;

   typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_e;

   // Two's-complement magnitude when neg is set; 0x80000000 stays as unsigned 2^31.
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract D, set the quotient bit.
module div_step
   import rv_muldiv_pkg::*;
(
   input  logic [2*XLEN-1:0] rq_i,
   input  logic [XLEN-1:0]   d_i,
   output logic [2*XLEN-1:0] rq_o
);
   logic [XLEN:0] rs;
   logic [XLEN:0] t;

   // R < D holds between steps, so a 33-bit trial difference is enough.
   assign rs = rq_i[2*XLEN-1:XLEN-1];
   assign t  = rs - {1'b0, d_i};

   always_comb begin
      if (t[XLEN]) rq_o = {rs[XLEN-1:0], rq_i[XLEN-2:0], 1'b0};
      else         rq_o = {t[XLEN-1:0],  rq_i[XLEN-2:0], 1'b1};
   end
endmodule

// File: rtl/divider.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU with a last-operand result cache.
module divider
   import rv_muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            us,
   input  logic            rem,
   input  logic            load,
   output logic            busy,
   output logic [XLEN-1:0] out
);
   localparam logic [4:0] CNT_INIT = 5'(DIV_STEPS - 1);

   div_state_e      state_q, state_d;
   logic [XLEN-1:0] ca_q, ca_d, cb_q, cb_d;
   logic            cus_q, cus_d, cvalid_q, cvalid_d;
   logic [2*XLEN-1:0] rq_q, rq_d, rq_step;
   logic [XLEN-1:0] dv_q, dv_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            nq_q, nq_d, nr_q, nr_d;
   logic [XLEN-1:0] qres_q, qres_d, rres_q, rres_d;
   logic            iload;

   assign iload = load & (~cvalid_q | ({ca_q, cb_q, cus_q} != {a, b, us}));
   assign busy  = iload | (state_q != IDLE);
   assign out   = rem ? rres_q : qres_q;

   div_step u_step (.rq_i(rq_q), .d_i(dv_q), .rq_o(rq_step));

   always_comb begin
      state_d  = state_q;
      ca_d     = ca_q;
      cb_d     = cb_q;
      cus_d    = cus_q;
      cvalid_d = cvalid_q;
      rq_d     = rq_q;
      dv_d     = dv_q;
      cnt_d    = cnt_q;
      nq_d     = nq_q;
      nr_d     = nr_q;
      qres_d   = qres_q;
      rres_d   = rres_q;
      case (state_q)
         RUN: begin
            rq_d  = rq_step;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_d = FIX;
         end
         FIX: begin
            qres_d  = nq_q ? (~rq_q[XLEN-1:0] + 1'b1) : rq_q[XLEN-1:0];
            rres_d  = nr_q ? (~rq_q[2*XLEN-1:XLEN] + 1'b1) : rq_q[2*XLEN-1:XLEN];
            state_d = IDLE;
         end
         default: ;
      endcase
      // A new operand set restarts from any state.
      if (iload) begin
         ca_d     = a;
         cb_d     = b;
         cus_d    = us;
         cvalid_d = 1'b1;
         rq_d     = {{XLEN{1'b0}}, mag(a, ~us & a[XLEN-1])};
         dv_d     = mag(b, ~us & b[XLEN-1]);
         cnt_d    = CNT_INIT;
         nq_d     = ~us & (a[XLEN-1] ^ b[XLEN-1]) & (b != '0);
         nr_d     = ~us & a[XLEN-1];
         state_d  = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ca_q     <= '0;
         cb_q     <= '0;
         cus_q    <= 1'b0;
         cvalid_q <= 1'b0;
         rq_q     <= '0;
         dv_q     <= '0;
         cnt_q    <= '0;
         nq_q     <= 1'b0;
         nr_q     <= 1'b0;
         qres_q   <= '0;
         rres_q   <= '0;
      end else begin
         state_q  <= state_d;
         ca_q     <= ca_d;
         cb_q     <= cb_d;
         cus_q    <= cus_d;
         cvalid_q <= cvalid_d;
         rq_q     <= rq_d;
         dv_q     <= dv_d;
         cnt_q    <= cnt_d;
         nq_q     <= nq_d;
         nr_q     <= nr_d;
         qres_q   <= qres_d;
         rres_q   <= rres_d;
      end
   end
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected result and stall length queued at issue, checked when busy drops.
module tb_divider;
   logic        clk = 1'b0;
   logic        reset, us, rem, load, busy;
   logic [31:0] a, b, out;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          stall_q[$];

   always #5 clk = ~clk;

   divider dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .us(us), .rem(rem),
      .load(load), .busy(busy), .out(out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic u, input logic r);
      if (y == 0) return r ? x : 32'hFFFF_FFFF;
      if (u) return r ? (x % y) : (x / y);
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'h0 : 32'h8000_0000;
      return r ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
   endfunction

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic u, input logic r);
      @(posedge clk); #1;
      a = x; b = y; us = u; rem = r; load = 1'b1;
   endtask

   task automatic push(input logic [31:0] x, input logic [31:0] y, input logic u,
                       input logic r, input int stall);
      exp_q.push_back(model(x, y, u, r));
      stall_q.push_back(stall);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      logic [31:0] e;
      int s;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      if (busy) chk({tag, "_timeout"}, 32'(busy), 32'h0);
      e = exp_q.pop_front();
      s = stall_q.pop_front();
      chk({tag, "_stall"}, 32'(n), 32'(s));
      chk({tag, "_out"}, out, e);
   endtask

   task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic u, input logic r, input int stall);
      push(x, y, u, r, stall);
      drive(x, y, u, r);
      wait_done(tag);
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; a = '0; b = '0; us = 1'b0; rem = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_out", out, 32'h0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_out", out, 32'h0);

      // Unsigned 100/7, then flip rem while still loaded: combinational remainder.
      op("divu", 32'd100, 32'd7, 1'b1, 1'b0, 34);
      push(32'd100, 32'd7, 1'b1, 1'b1, 0);
      drive(32'd100, 32'd7, 1'b1, 1'b1);
      wait_done("remu_hit");
      @(posedge clk); #1 load = 1'b0;
      op("remu_hit2", 32'd100, 32'd7, 1'b1, 1'b1, 0);
      op("rem_us_chg", 32'd100, 32'd7, 1'b0, 1'b1, 34);

      op("div_neg", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 34);
      op("rem_neg", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 0);
      op("div_z_s", 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 34);
      op("rem_z_s", 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1, 0);
      op("div_z_u", 32'd5, 32'd0, 1'b1, 1'b0, 34);
      op("rem_z_u", 32'd5, 32'd0, 1'b1, 1'b1, 0);
      op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
      op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
      op("rem_negb", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 34);

      // Operand change mid-run restarts the full 34-cycle stall.
      drive(32'd100, 32'd7, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      push(32'd50, 32'd7, 1'b1, 1'b0, 34);
      @(posedge clk); #1 a = 32'd50;
      wait_done("restart");
      @(posedge clk); #1 load = 1'b0;

      // Reset at L+10 aborts and invalidates the cache.
      drive(32'd1000, 32'd3, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      @(posedge clk); #1 reset = 1'b1; load = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_out", out, 32'h0);
      op("zero_zero", 32'd0, 32'd0, 1'b0, 1'b0, 34);

      for (int i = 0; i < 8; i++) begin
         logic [31:0] x, y;
         logic u, r;
         x = $urandom;
         y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i[0]) y = -y;
         u = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         op("rnd", x, y, u, r, 34);
         op("rnd_hit", x, y, u, ~r, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/divider.md
# divider

Iterative 32-bit integer divider for the RV32IM DIV/DIVU/REM/REMU instructions. It is the inverse companion of the core's shift-register multiplier and shares that block's load/busy/out handshake, so the execute stage drives both units the same way. It retires one quotient bit per cycle with a restoring algorithm and applies RISC-V sign, divide-by-zero and overflow rules. It caches the last operands, so a DIV followed by a REM on the same operands (or the reverse) completes without recomputation.

## Interface
Parameters: none. Width is fixed at 32.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- a  in  32  dividend (rs1)
- b  in  32  divisor (rs2)
- us  in  1  1 = unsigned operation (DIVU/REMU), 0 = signed
- rem  in  1  1 = output the remainder, 0 = output the quotient
- load  in  1  start strobe; held high, with stable operands, for the whole stall
- busy  out  1  high while the result is not valid; core stalls on it
- out  out  32  selected result; valid whenever busy = 0

## Operation
- Cache registers: ca, cb, cus, cvalid. Loaded on iload. Reset gives cvalid = 0 and the other cache registers 0.
- iload = load & (~cvalid | {ca,cb,cus} != {a,b,us}). It is evaluated in every state; if operands change mid-run, the run restarts.
- Magnitudes:
  - signed mode: |a| and |b| by two's complement; 0x80000000 maps to unsigned 2^31.
  - unsigned mode: the operands pass unchanged.
- Flags latched on iload:
  - nq = ~us & (a[31] ^ b[31]) & (b != 0)
  - nr = ~us & a[31]
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on iload. This loads the 64-bit working register {R = 0, Q = |a|}, the divisor magnitude D, and cnt = 31.
  - RUN, each cycle:
    - shift {R,Q} left by 1
    - compute T = R_shifted − D (33-bit)
    - if T is non-negative, R = T[31:0] and the Q LSB = 1; otherwise the Q LSB = 0
    - cnt decrements; leave for FIX when cnt = 0
  - FIX: qres = nq ? −Q : Q and rres = nr ? −R : R; then go to IDLE.
  - iload in RUN or FIX reloads immediately and stays in or re-enters RUN.
- Divide by zero falls out with no special path: Q = 0xFFFFFFFF and R = |a|. The guard on nq keeps the quotient at −1 and gives the remainder the dividend's sign, so out = a.
- Overflow (0x80000000 / 0xFFFFFFFF, signed): Q = 0x80000000, nq = 0, so quotient = 0x80000000 and remainder = 0. No special path.
- out = rem ? rres : qres. This is combinational on rem, so changing only rem returns the other result with no recomputation.
- busy = iload | (state != IDLE).

## Timing
- Reset values: state = IDLE, cvalid = 0, qres = rres = 0, busy = 0 (when load = 0), out = 0.
- Cycle L is the first cycle with iload; busy goes high combinationally in that cycle.
- RUN occupies cycles L+1 to L+32 and FIX is L+33.
- busy falls in cycle L+34 and out is valid in that same cycle. Stall: 34 cycles.
- Cache hit (same a, b, us; rem may differ): busy = 0 in the load cycle and out is valid in that cycle.
- Reset in any state wins over load, aborts the run and invalidates the cache. The next load always recomputes.
- Throughput: one division per 34 cycles; no pipelining.

## Structure
- Shared package (`rv_muldiv_pkg`): XLEN = 32, the state enumeration {IDLE, RUN, FIX}, and the iteration count constant DIV_STEPS = 32.
- One sub-module is natural: `div_step`. It is combinational; it takes {R,Q} and D and returns the next {R,Q}, to allow a later radix-4 variant by instancing it twice.
- Sign conversion and FIX negation stay inline.

## Test plan
- Unsigned: a = 100, b = 7, us = 1. rem = 0 gives out = 14; rem = 1 gives out = 2. busy is high exactly 34 cycles.
- Signed: a = 0xFFFFFFF9 (−7), b = 2. Quotient = 0xFFFFFFFD (−3); remainder = 0xFFFFFFFF (−1).
- Divide by zero: signed a = 0xFFFFFFFB (−5), b = 0 gives quotient 0xFFFFFFFF and remainder 0xFFFFFFFB. Unsigned a = 5, b = 0 gives 0xFFFFFFFF and 5.
- Overflow: a = 0x80000000, b = 0xFFFFFFFF, us = 0. Quotient 0x80000000, remainder 0.
- Cache: DIV 100/7 completes, then load again with the same a, b, us and rem = 1. busy stays 0 and out = 2 in that cycle. Changing us to 0 with the same operands forces a full 34-cycle run.
- Reset mid-run: assert reset at cycle L+10. Next cycle: state IDLE, busy = 0, out = 0. A reload of 0/0 then recomputes and gives quotient 0xFFFFFFFF.
